// File: rtl/leaf_collect_pkg.sv
// Shared types for the leaf result collector.
//   DATA_W_DEFAULT : default leaf result word width
//   state_t        : collector run state
//   lane_id_t      : source lane ID carried with each word when tagging is built in
package leaf_collect_pkg;

  localparam int DATA_W_DEFAULT = 35;
  localparam int NUM_LANES      = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef logic [1:0] lane_id_t;

  localparam lane_id_t LANE_A = 2'd0;
  localparam lane_id_t LANE_B = 2'd1;
  localparam lane_id_t LANE_C = 2'd2;

endpackage

// File: rtl/leaf_fifo_3w1r.sv
// FIFO with three compacting write ports and one read port.
// Enabled write lanes land in consecutive slots from wr_ptr in lane order
// (lane 0 first); disabled lanes leave no hole. The caller must never enable
// more lanes than 'free' reports.
//   clk, reset    : clock, asynchronous active-high reset
//   wr_en/wr_data : per-lane write enable and word
//   rd_en         : pop the head word (ignored when empty)
//   rd_data       : head word, zero while empty
//   count/free    : occupancy and free slots at cycle start
module leaf_fifo_3w1r
  import leaf_collect_pkg::*;
#(
  parameter int W     = DATA_W_DEFAULT,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        wr_en,
  input  logic [NUM_LANES-1:0][W-1:0] wr_data,
  input  logic                        rd_en,
  output logic [W-1:0]                rd_data,
  output logic [CW-1:0]               count,
  output logic [CW-1:0]               free
);

  logic [DEPTH-1:0][W-1:0]     mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [NUM_LANES-1:0][1:0]   slot_off;
  logic [1:0]                  n_push;
  logic                        not_empty, pop;

  // Each lane's slot offset is the number of enabled lanes ahead of it.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      slot_off[i] = n_push;
      n_push      = n_push + 2'(wr_en[i]);
    end
  end

  assign not_empty = (count != '0);
  assign pop       = rd_en & not_empty;
  assign free      = CW'(DEPTH) - count;
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  // Storage needs no reset; the read side is masked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (wr_en[i]) mem[wr_ptr + AW'(slot_off[i])] <= wr_data[i];
  end

endmodule

// File: rtl/leaf_result_collector.sv
// Collects leaf results from lanes A/B/C on scheduler strobes, buffers them in
// a 3-write/1-read FIFO and drains them as a valid/ready stream. A run accepts
// exactly NUM_LEAVES words; m_last marks the final one and done follows its
// handshake. Lanes that cannot be accepted (no space, cap reached, or not
// collecting) set the sticky overflow flag.
// Build option: LEAF_COLLECT_TAG_EN adds m_tag[1:0] (source lane ID, 0=A,
// 1=B, 2=C) stored alongside each word.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a run from IDLE/DONE
//   strobe, res_a/b/c   : lane sample strobe and lane results (nonzero = valid)
//   m_valid/m_ready     : output stream handshake; m_data, m_last (, m_tag)
//   leaf_count          : words emitted this run
//   overflow, busy, done: status
module leaf_result_collector
  import leaf_collect_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int NUM_LEAVES = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              strobe,
  input  logic [DATA_W-1:0] res_a,
  input  logic [DATA_W-1:0] res_b,
  input  logic [DATA_W-1:0] res_c,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
`ifdef LEAF_COLLECT_TAG_EN
  output logic [1:0]        m_tag,
`endif
  output logic              m_last,
  output logic [7:0]        leaf_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
`ifdef LEAF_COLLECT_TAG_EN
  localparam int FW = DATA_W + 2;
`else
  localparam int FW = DATA_W;
`endif

  state_t                          state, state_nx;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_res;
  logic [NUM_LANES-1:0]            lane_nz, acc_en;
  logic [NUM_LANES-1:0][FW-1:0]    fifo_wd;
  logic [FW-1:0]                   fifo_rd;
  logic [AW:0]                     fifo_cnt, fifo_free;
  logic [7:0]                      acc_cnt;
  logic [8:0]                      room_left, room, taken;
  logic                            collecting, start_run, hs, dropped;

  assign lane_res = {res_c, res_b, res_a};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_nz[i] = |lane_res[i];
`ifdef LEAF_COLLECT_TAG_EN
    assign fifo_wd[i] = {lane_id_t'(i), lane_res[i]};
`else
    assign fifo_wd[i] = lane_res[i];
`endif
  end

  assign collecting = (state == S_COLLECT);
  assign start_run  = start & ((state == S_IDLE) | (state == S_DONE));
  assign hs         = m_valid & m_ready;

  // Accept the first 'room' valid lanes in A,B,C order, where room is the
  // tighter of FIFO space at cycle start and leaves still owed this run.
  always_comb begin
    room_left = 9'(NUM_LEAVES) - 9'(acc_cnt);
    room      = (9'(fifo_free) < room_left) ? 9'(fifo_free) : room_left;
    acc_en    = '0;
    taken     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (collecting & strobe & lane_nz[i] & (taken < room)) begin
        acc_en[i] = 1'b1;
        taken     = taken + 9'd1;
      end
    end
  end

  // Any strobed valid lane not accepted is a drop, whatever the state.
  assign dropped = strobe & (acc_en != lane_nz);

  leaf_fifo_3w1r #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (acc_en),
    .wr_data (fifo_wd),
    .rd_en   (m_ready),
    .rd_data (fifo_rd),
    .count   (fifo_cnt),
    .free    (fifo_free)
  );

  assign m_valid = (fifo_cnt != '0);
  assign m_data  = fifo_rd[DATA_W-1:0];
`ifdef LEAF_COLLECT_TAG_EN
  assign m_tag   = fifo_rd[FW-1:DATA_W];
`endif
  assign m_last  = m_valid & (leaf_count == 8'(NUM_LEAVES - 1));
  assign busy    = (state == S_COLLECT) | (state == S_DRAIN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_COLLECT;
      S_COLLECT:      if (9'(acc_cnt) + taken == 9'(NUM_LEAVES)) state_nx = S_DRAIN;
      S_DRAIN:        if (hs & m_last) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt    <= '0;
      leaf_count <= '0;
      overflow   <= 1'b0;
    end else if (start_run) begin
      acc_cnt    <= '0;
      leaf_count <= '0;
      overflow   <= 1'b0;
    end else begin
      acc_cnt <= acc_cnt + 8'(taken);
      if (hs)      leaf_count <= leaf_count + 8'd1;
      if (dropped) overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_result_collector.sv
// Scoreboard bench for leaf_result_collector. The driver predicts, per strobe,
// which lanes a run can still take (space = DEPTH minus words not yet drained,
// capped by leaves still owed) and queues them; the monitor compares every
// presented word against the queue head. NUM_LEAVES is set above DEPTH so the
// FIFO space limit is reachable inside one run.
module tb_leaf_result_collector;

  localparam int DATA_W     = 35;
  localparam int DEPTH      = 8;
  localparam int NUM_LEAVES = 12;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct packed {
    logic [1:0] tag;
    word_t      data;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, strobe = 1'b0, m_ready = 1'b0;
  word_t      res_a = '0, res_b = '0, res_c = '0;
  logic       m_valid, m_last, overflow, busy, done;
  word_t      m_data;
  logic [7:0] leaf_count;
`ifdef LEAF_COLLECT_TAG_EN
  logic [1:0] m_tag;
`endif

  leaf_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_LEAVES(NUM_LEAVES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .strobe     (strobe),
    .res_a      (res_a),
    .res_b      (res_b),
    .res_c      (res_c),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef LEAF_COLLECT_TAG_EN
    .m_tag      (m_tag),
`endif
    .m_last     (m_last),
    .leaf_count (leaf_count),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  exp_t exp_q[$];
  int   pending = 0;        // words queued for the coming edge, not yet visible
  bit   running = 0, completed = 0, ovf_exp = 0;
  int   acc = 0, emitted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  function automatic word_t rnd_nz();
    return word_t'({$urandom(), $urandom()}) | word_t'(1);
  endfunction

  function automatic word_t rnd_lane();
    return ($urandom_range(9) < 4) ? word_t'(0) : rnd_nz();
  endfunction

  // One cycle of stimulus plus model update for the coming edge.
  task automatic cyc(input bit st, input bit sb, input word_t a, input word_t b,
                     input word_t c, input bit rdy);
    word_t lanes[3];
    exp_t  e;
    int    space;
    @(negedge clk);
    check("overflow", overflow, ovf_exp);
    check("busy", busy, running);
    check("done", done, completed);
    start = st; strobe = sb; res_a = a; res_b = b; res_c = c; m_ready = rdy;
    pending = 0;
    if (st && !running) begin
      running = 1; completed = 0; acc = 0; emitted = 0; ovf_exp = 0;
    end
    if (sb) begin
      lanes = '{a, b, c};
      space = DEPTH - exp_q.size();
      for (int i = 0; i < 3; i++) begin
        if (lanes[i] != 0) begin
          if (running && acc < NUM_LEAVES && space > 0) begin
            e.data = lanes[i];
            e.tag  = 2'(i);
            exp_q.push_back(e);
            acc++; space--; pending++;
          end else begin
            ovf_exp = 1;
          end
        end
      end
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, '0, '0, '0, rdy);
  endtask

  task automatic drain(input int rdy_pct);
    int n = 0;
    while (!completed && n < 500) begin
      idle($urandom_range(99) < rdy_pct);
      n++;
    end
    tests++;
    if (!completed) begin
      fails++;
      $display("FAIL drain_timeout: run did not complete, emitted %0d want %0d", emitted, NUM_LEAVES);
    end
    idle(1);
  endtask

  task automatic full_run();
    cyc(1, 0, '0, '0, '0, 1);
    for (int s = 0; s < NUM_LEAVES / 3; s++) begin
      cyc(0, 1, rnd_nz(), rnd_nz(), rnd_nz(), 1);
      idle(1);
      idle(1);
    end
    drain(100);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; strobe = 0; res_a = '0; res_b = '0; res_c = '0; m_ready = 0;
    #2;
    check("reset_m_valid", m_valid, 0);
    check("reset_leaf_count", leaf_count, 0);
    exp_q.delete();
    pending = 0; running = 0; completed = 0; ovf_exp = 0; acc = 0; emitted = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic random_run();
    int n = 0;
    bit sb, st;
    cyc(1, 0, '0, '0, '0, 1'($urandom_range(1)));
    while (!completed && n < 3000) begin
      sb = 1'($urandom_range(1));
      st = !sb && running && ($urandom_range(19) == 0);
      cyc(st, sb, rnd_lane(), rnd_lane(), rnd_lane(), $urandom_range(99) < 60);
      n++;
    end
    tests++;
    if (!completed) begin
      fails++;
      $display("FAIL random_timeout: emitted %0d want %0d", emitted, NUM_LEAVES);
    end
    idle(1);
  endtask

  // Monitor: samples just after the driver sets inputs, well before the edge.
  bit    prev_stall = 0, prev_last = 0;
  word_t prev_data = '0;
  initial begin
    exp_t e;
    int   visible;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        visible = exp_q.size() - pending;
        check("m_valid", m_valid, visible > 0);
        if (m_valid && visible > 0) begin
          e = exp_q[0];
          check("m_data", m_data, e.data);
`ifdef LEAF_COLLECT_TAG_EN
          check("m_tag", m_tag, e.tag);
`endif
          check("m_last", m_last, emitted == NUM_LEAVES - 1);
          check("leaf_count", leaf_count, emitted);
          if (m_ready) begin
            void'(exp_q.pop_front());
            emitted++;
            if (emitted == NUM_LEAVES) begin
              running = 0;
              completed = 1;
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_leaf_count", leaf_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 0;

    // Sparse lanes: A and C only, B skipped without a hole.
    cyc(1, 0, '0, '0, '0, 1);
    cyc(0, 1, 35'h1, 35'h0, 35'h3, 1);
    idle(1); idle(1); idle(1);
    check("sparse_leaf_count", leaf_count, 2);
    cyc(0, 1, 35'h5, 35'h6, 35'h7, 1);
    cyc(0, 1, 35'h8, 35'h9, 35'ha, 1);
    idle(1);
    cyc(0, 1, 35'hb, 35'h0, 35'hc, 1);
    idle(1);
    cyc(0, 1, 35'h0, 35'hd, 35'he, 1);
    drain(100);
    check("sparse_done", done, 1);

    // Full run with all lanes valid, no drops.
    full_run();
    check("full_overflow", overflow, 0);
    check("full_leaf_count", leaf_count, NUM_LEAVES);
    check("full_done", done, 1);

    // FIFO fills with the consumer stalled: lane C of the third strobe drops.
    cyc(1, 0, '0, '0, '0, 0);
    cyc(0, 1, 35'h101, 35'h102, 35'h103, 0);
    cyc(0, 1, 35'h104, 35'h105, 35'h106, 0);
    cyc(0, 1, 35'h107, 35'h108, 35'h109, 0);
    idle(0);
    check("full_fifo_overflow", overflow, 1);
    repeat (8) idle(1);
    cyc(0, 1, 35'h10a, 35'h10b, 35'h10c, 1);
    idle(1); idle(1);
    cyc(0, 1, 35'h10d, 35'h10e, 35'h10f, 1);  // cap: only A taken
    drain(100);

    // Strobe while draining is ignored but flagged.
    cyc(1, 0, '0, '0, '0, 1);
    for (int s = 0; s < NUM_LEAVES / 3; s++) begin
      cyc(0, 1, rnd_nz(), rnd_nz(), rnd_nz(), 1);
      idle(1); idle(1);
    end
    cyc(0, 1, 35'h7a, 35'h7b, 35'h7c, 0);
    idle(0);
    check("drain_strobe_overflow", overflow, 1);
    drain(100);

    // Reset with words buffered, then a clean run.
    cyc(1, 0, '0, '0, '0, 0);
    cyc(0, 1, 35'h201, 35'h202, 35'h203, 0);
    cyc(0, 1, 35'h204, 35'h0, 35'h0, 0);
    idle(0);
    do_reset();
    full_run();
    check("post_reset_done", done, 1);

    // Randomized runs with backpressure; pointers wrap across runs.
    for (int r = 0; r < 4; r++) random_run();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/leaf_result_collector.md
# leaf_result_collector

Downstream of the tree scheduler. Captures leaf-sequence results from the three leaf-producing PE lanes (A, B, C) on each scheduling strobe and packs them into a 3-write/1-read FIFO. Drains them as a valid/ready stream toward the result writer. Counts delivered leaves and flags completion when the expected leaf count has been emitted.

## Interface
- DATA_W, 35, leaf result word width
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- NUM_LEAVES, 7, leaves expected per tree run; 1..255

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run (IDLE/DONE → COLLECT)
- strobe  in  1  scheduler step pulse; lanes sampled only when high
- res_a, res_b, res_c  in  DATA_W each  lane result; nonzero means valid leaf
- m_valid  out  1  output word valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_W  output leaf word
- m_last  out  1  high with the NUM_LEAVES-th emitted word
- leaf_count  out  8  words emitted this run
- overflow  out  1  sticky; a valid lane was dropped
- busy  out  1  high in COLLECT or DRAIN
- done  out  1  high in DONE

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
  - IDLE → COLLECT on start.
  - COLLECT → DRAIN when accepted count reaches NUM_LEAVES.
  - DRAIN → DONE on the handshake of the m_last word.
  - DONE → COLLECT on start. A new run clears leaf_count, the accepted count, and overflow.
- Capture happens in COLLECT only, on `strobe & (res_x != 0)`.
  - Lanes are written in fixed order A, B, C into consecutive slots from wr_ptr. Invalid lanes are skipped without leaving holes.
- Space check: free = DEPTH − count at cycle start.
  - A pop in the same cycle does not free space for that cycle's pushes.
  - Lanes beyond free space are dropped in order (C first, then B) and overflow is set.
- Accepted words are also capped at NUM_LEAVES. Lanes beyond the cap are dropped and set overflow.
- Strobes in IDLE, DRAIN, or DONE are ignored. A nonzero lane seen in those states sets overflow.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- leaf_count increments on each m_valid & m_ready. m_last = m_valid & (leaf_count == NUM_LEAVES−1).
- start while busy is ignored.

## Timing
- All outputs reset to 0; state resets to IDLE; pointers and count reset to 0.
- Capture-to-output latency: 1 cycle. A word written at edge N is presented on m_valid after edge N if the FIFO was empty.
- While m_valid & !m_ready, m_data, m_last, and m_valid hold stable.
- Push and pop in the same cycle are both honored: count += pushes − pop.
- done asserts the cycle after the m_last handshake.
- Reset mid-run abandons all FIFO contents; no output is produced until the next start.

## Configuration
- LEAF_COLLECT_TAG_EN
  - Defined: FIFO stores 2 extra bits of source-lane ID (0=A, 1=B, 2=C), presented on an added output port m_tag [1:0] that is aligned with m_data.
  - Undefined: no port, FIFO width DATA_W, identical ordering and timing.

## Structure
- Package leaf_collect_pkg:
  - DATA_W default
  - state enum
  - lane ID type and constants LANE_A/B/C
- Sub-module leaf_fifo_3w1r: FIFO with 3 compacting write ports and 1 read port, exposing count/free. The FSM, caps, counters, and flags stay in the top.

## Test plan
- start; strobe with A=0x1, B=0, C=0x3 → output 0x1 then 0x3 on consecutive ready cycles; leaf_count=2.
- NUM_LEAVES=7; three strobes of 3, 3, 1 valid lanes, m_ready=1 → 7 words in A,B,C order; m_last on the 7th; done next cycle; overflow=0.
- m_ready=0, DEPTH=8; three strobes with all lanes valid → 8 words stored; the 9th (lane C, 3rd strobe) is dropped; overflow=1; draining yields 8 words in order.
- Lanes valid in a strobe during DRAIN → ignored, overflow=1, leaf_count unaffected.
- Reset asserted with 4 words buffered → m_valid=0 immediately; after release a fresh start/run outputs only new words.
- Random m_ready backpressure over 4 runs with pointer wrap → scoreboard-exact order; m_data stable while stalled.
